// File: rtl/sevseg_byte_reader_if.sv
// Pin-side bundle of the seven-segment receive link: raw segment/select inputs
// plus the reconstructed-byte outputs.
interface sevseg_byte_reader_if;
    logic [6:0] sevseg_led;
    logic       sevseg_sel;
    logic [7:0] byte_data;
    logic       data_valid;
    logic       update;
    logic       pattern_err;

    modport master (
        output sevseg_led, sevseg_sel,
        input  byte_data, data_valid, update, pattern_err
    );

    modport slave (
        input  sevseg_led, sevseg_sel,
        output byte_data, data_valid, update, pattern_err
    );
endinterface

// File: rtl/sevseg_byte_reader.sv
// Receives a two-digit multiplexed active-low seven-segment bus, decodes both
// digits and publishes the displayed byte once it is stable over several frames.
module sevseg_byte_reader #(
    parameter int unsigned SETTLE        = 16,
    parameter int unsigned STABLE_FRAMES = 2,
    parameter int unsigned TIMEOUT       = 65536,
    parameter bit          HIGH_WHEN_SEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    sevseg_byte_reader_if.slave  bus
);
    localparam int unsigned SW = $clog2(SETTLE);
    localparam int unsigned TW = $clog2(TIMEOUT);
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);
    localparam logic [3:0]    STABLE_N    = 4'(STABLE_FRAMES);

    typedef enum logic [1:0] {WAIT_EDGE, SETTLING, SAMPLE, COMMIT} state_t;

    state_t         state_q, state_d;
    logic [SW-1:0]  settle_cnt_q, settle_cnt_d;
    logic [TW-1:0]  to_cnt_q, to_cnt_d;
    logic           edge_pend_q, edge_pend_d;
    logic [3:0]     hi_nib_q, hi_nib_d, lo_nib_q, lo_nib_d;
    logic           hi_flag_q, hi_flag_d, lo_flag_q, lo_flag_d;
    logic [3:0]     match_q, match_d;
    logic [7:0]     prev_q, prev_d;
    logic [7:0]     byte_data_q, byte_data_d;
    logic           data_valid_q, data_valid_d;
    logic           update_q, update_d;
    logic           pattern_err_q, pattern_err_d;
    logic [6:0]     led_s1_q, led_s1_d, led_s2_q, led_s2_d;
    logic           sel_s1_q, sel_s1_d, sel_s2_q, sel_s2_d, sel_s3_q, sel_s3_d;

    logic           sel_edge;
    logic           is_high;
    logic [4:0]     dec;
    logic [7:0]     cand;

    function automatic logic [4:0] decode(input logic [6:0] p);
        logic [4:0] r;
        r = '0;
        case (p)
            7'h3F: r = {1'b1, 4'h0};
            7'h06: r = {1'b1, 4'h1};
            7'h5B: r = {1'b1, 4'h2};
            7'h4F: r = {1'b1, 4'h3};
            7'h66: r = {1'b1, 4'h4};
            7'h6D: r = {1'b1, 4'h5};
            7'h7D: r = {1'b1, 4'h6};
            7'h07: r = {1'b1, 4'h7};
            7'h7F: r = {1'b1, 4'h8};
            7'h6F: r = {1'b1, 4'h9};
            7'h77: r = {1'b1, 4'hA};
            7'h7C: r = {1'b1, 4'hB};
            7'h39: r = {1'b1, 4'hC};
            7'h5E: r = {1'b1, 4'hD};
            7'h79: r = {1'b1, 4'hE};
            7'h71: r = {1'b1, 4'hF};
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        led_s1_d = bus.sevseg_led;
        led_s2_d = led_s1_q;
        sel_s1_d = bus.sevseg_sel;
        sel_s2_d = sel_s1_q;
        sel_s3_d = sel_s2_q;

        sel_edge = sel_s2_q ^ sel_s3_q;
        dec      = decode(~led_s2_q);
        is_high  = (sel_s2_q == HIGH_WHEN_SEL);
        cand     = {hi_nib_q, lo_nib_q};

        state_d       = state_q;
        settle_cnt_d  = settle_cnt_q;
        edge_pend_d   = edge_pend_q;
        hi_nib_d      = hi_nib_q;
        lo_nib_d      = lo_nib_q;
        hi_flag_d     = hi_flag_q;
        lo_flag_d     = lo_flag_q;
        match_d       = match_q;
        prev_d        = prev_q;
        byte_data_d   = byte_data_q;
        data_valid_d  = data_valid_q;
        update_d      = 1'b0;
        pattern_err_d = 1'b0;

        case (state_q)
            WAIT_EDGE: begin
                if (sel_edge) begin
                    state_d      = SETTLING;
                    settle_cnt_d = '0;
                end
            end
            SETTLING: begin
                edge_pend_d = 1'b0;
                if (sel_edge) begin
                    settle_cnt_d = '0;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = SAMPLE;
                end else begin
                    settle_cnt_d = settle_cnt_q + SW'(1);
                end
            end
            SAMPLE: begin
                // An edge here must survive the COMMIT cycle to restart settling.
                edge_pend_d = sel_edge;
                if (dec[4]) begin
                    if (is_high) begin
                        hi_nib_d  = dec[3:0];
                        hi_flag_d = 1'b1;
                    end else begin
                        lo_nib_d  = dec[3:0];
                        lo_flag_d = 1'b1;
                    end
                end else begin
                    pattern_err_d = 1'b1;
                    hi_flag_d     = 1'b0;
                    lo_flag_d     = 1'b0;
                    match_d       = '0;
                end
                if (dec[4] && !is_high) begin
                    state_d = COMMIT;
                end else if (sel_edge) begin
                    state_d      = SETTLING;
                    settle_cnt_d = '0;
                end else begin
                    state_d = WAIT_EDGE;
                end
            end
            COMMIT: begin
                if (hi_flag_q) begin
                    if (cand == prev_q) begin
                        match_d = (match_q == 4'hF) ? match_q : match_q + 4'd1;
                    end else begin
                        match_d = 4'd1;
                        prev_d  = cand;
                    end
                    if (match_d >= STABLE_N && (cand != byte_data_q || !data_valid_q)) begin
                        byte_data_d  = cand;
                        data_valid_d = 1'b1;
                        update_d     = 1'b1;
                    end
                end
                hi_flag_d   = 1'b0;
                lo_flag_d   = 1'b0;
                edge_pend_d = 1'b0;
                if (sel_edge || edge_pend_q) begin
                    state_d      = SETTLING;
                    settle_cnt_d = '0;
                end else begin
                    state_d = WAIT_EDGE;
                end
            end
            default: state_d = WAIT_EDGE;
        endcase

        to_cnt_d = sel_edge ? '0 : ((to_cnt_q == TO_LAST) ? to_cnt_q : to_cnt_q + TW'(1));
        // Lost select overrides any commit in the same cycle; byte_data is kept.
        if (to_cnt_q == TO_LAST) begin
            data_valid_d = 1'b0;
            update_d     = 1'b0;
            match_d      = '0;
            prev_d       = '0;
            hi_flag_d    = 1'b0;
            lo_flag_d    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= WAIT_EDGE;
            settle_cnt_q  <= '0;
            to_cnt_q      <= '0;
            edge_pend_q   <= 1'b0;
            hi_nib_q      <= '0;
            lo_nib_q      <= '0;
            hi_flag_q     <= 1'b0;
            lo_flag_q     <= 1'b0;
            match_q       <= '0;
            prev_q        <= '0;
            byte_data_q   <= '0;
            data_valid_q  <= 1'b0;
            update_q      <= 1'b0;
            pattern_err_q <= 1'b0;
            led_s1_q      <= '1;
            led_s2_q      <= '1;
            sel_s1_q      <= 1'b0;
            sel_s2_q      <= 1'b0;
            sel_s3_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            settle_cnt_q  <= settle_cnt_d;
            to_cnt_q      <= to_cnt_d;
            edge_pend_q   <= edge_pend_d;
            hi_nib_q      <= hi_nib_d;
            lo_nib_q      <= lo_nib_d;
            hi_flag_q     <= hi_flag_d;
            lo_flag_q     <= lo_flag_d;
            match_q       <= match_d;
            prev_q        <= prev_d;
            byte_data_q   <= byte_data_d;
            data_valid_q  <= data_valid_d;
            update_q      <= update_d;
            pattern_err_q <= pattern_err_d;
            led_s1_q      <= led_s1_d;
            led_s2_q      <= led_s2_d;
            sel_s1_q      <= sel_s1_d;
            sel_s2_q      <= sel_s2_d;
            sel_s3_q      <= sel_s3_d;
        end
    end

    assign bus.byte_data   = byte_data_q;
    assign bus.data_valid  = data_valid_q;
    assign bus.update      = update_q;
    assign bus.pattern_err = pattern_err_q;
endmodule

// File: tb/tb_sevseg_byte_reader.sv
// Bench for sevseg_byte_reader: drives multiplexed digit phases and scores
// update/pattern_err events (value and cycle) against expected queue entries.
module tb_sevseg_byte_reader;
    localparam int unsigned SETTLE  = 16;
    localparam int unsigned STABLE  = 2;
    localparam int unsigned TIMEOUT = 4000;
    localparam int unsigned PHASE   = 200;
    localparam bit          HS      = 1'b0;

    typedef struct packed {
        logic       kind;   // 1 = update, 0 = pattern_err
        logic [7:0] data;
        int         cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   t_last;
    ev_t  exp_q[$];
    ev_t  obs_q[$];

    sevseg_byte_reader_if bus();

    sevseg_byte_reader #(
        .SETTLE(SETTLE),
        .STABLE_FRAMES(STABLE),
        .TIMEOUT(TIMEOUT),
        .HIGH_WHEN_SEL(HS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.update)      obs_q.push_back(ev_t'{1'b1, bus.byte_data, cyc});
        if (bus.pattern_err) obs_q.push_back(ev_t'{1'b0, 8'h00, cyc});
        if (bus.update || bus.pattern_err) begin
            total_cnt++;
            if ((bus.update && bus.pattern_err) || (bus.update && !bus.data_valid))
                $display("FAIL pulse_exclusive: update=%b pattern_err=%b data_valid=%b at cycle %0d",
                         bus.update, bus.pattern_err, bus.data_valid, cyc);
            else
                pass_cnt++;
        end
    end

    function automatic logic [6:0] seg(input logic [3:0] n);
        logic [6:0] p;
        case (n)
            4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
            4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
            4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
            4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
        endcase
        return p;
    endfunction

    // Called right after a negedge; drives one select phase carrying pattern pat.
    task automatic drive_phase(input logic sel, input logic [6:0] pat, input int unsigned n,
                               output int start);
        bus.sevseg_sel = sel;
        bus.sevseg_led = ~pat;
        start = cyc;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        bus.sevseg_sel = 1'b0;
        bus.sevseg_led = 7'h7F;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total_cnt++; if (bus.byte_data !== 8'h00) $display("FAIL reset_byte: got %h want 00", bus.byte_data); else pass_cnt++;
        total_cnt++; if (bus.data_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.data_valid); else pass_cnt++;
        total_cnt++; if (bus.update !== 1'b0) $display("FAIL reset_update: got %b want 0", bus.update); else pass_cnt++;
        total_cnt++; if (bus.pattern_err !== 1'b0) $display("FAIL reset_perr: got %b want 0", bus.pattern_err); else pass_cnt++;
        rst = 1'b0;
    endtask

    task automatic test_first_byte();
        int s;
        ev_t e, o;
        drive_phase(~HS, seg(4'h5), PHASE, s);
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, seg(4'h5), PHASE, s);
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, seg(4'h5), PHASE, s);
        exp_q.push_back(ev_t'{1'b1, 8'hA5, s + int'(SETTLE) + 5});
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, seg(4'h5), PHASE, s);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL first_byte_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
            if (o !== e) $display("FAIL first_byte_event: got kind=%b data=%h cyc=%0d want kind=%b data=%h cyc=%0d",
                                  o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        total_cnt++; if (bus.byte_data !== 8'hA5) $display("FAIL first_byte_data: got %h want A5", bus.byte_data); else pass_cnt++;
        total_cnt++; if (bus.data_valid !== 1'b1) $display("FAIL first_byte_valid: got %b want 1", bus.data_valid); else pass_cnt++;
    endtask

    task automatic test_pattern_err();
        int s;
        ev_t e, o;
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, 7'h12, PHASE, s);
        exp_q.push_back(ev_t'{1'b0, 8'h00, s + int'(SETTLE) + 4});
        repeat (2) begin
            drive_phase(HS,  seg(4'hA), PHASE, s);
            drive_phase(~HS, seg(4'h5), PHASE, s);
        end
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL perr_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
            if (o !== e) $display("FAIL perr_event: got kind=%b data=%h cyc=%0d want kind=%b data=%h cyc=%0d",
                                  o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        total_cnt++; if (bus.byte_data !== 8'hA5) $display("FAIL perr_byte_kept: got %h want A5", bus.byte_data); else pass_cnt++;
        total_cnt++; if (bus.data_valid !== 1'b1) $display("FAIL perr_valid_kept: got %b want 1", bus.data_valid); else pass_cnt++;
    endtask

    task automatic test_glitch();
        int s;
        ev_t e, o;
        drive_phase(HS,  7'h00, 2, s);
        drive_phase(~HS, 7'h00, 2, s);
        bus.sevseg_sel = HS;
        t_last = cyc;
        exp_q.push_back(ev_t'{1'b0, 8'h00, t_last + int'(SETTLE) + 4});
        repeat (PHASE) @(negedge clk);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL glitch_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
            if (o !== e) $display("FAIL glitch_event: got kind=%b data=%h cyc=%0d want kind=%b data=%h cyc=%0d",
                                  o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_timeout();
        int s;
        ev_t e, o;
        while (cyc < t_last + int'(TIMEOUT) + 2) @(negedge clk);
        total_cnt++; if (bus.data_valid !== 1'b1) $display("FAIL timeout_early: valid=%b want 1 at cycle %0d", bus.data_valid, cyc); else pass_cnt++;
        @(negedge clk);
        total_cnt++; if (bus.data_valid !== 1'b0) $display("FAIL timeout_drop: valid=%b want 0 at cycle %0d", bus.data_valid, cyc); else pass_cnt++;
        total_cnt++; if (bus.byte_data !== 8'hA5) $display("FAIL timeout_byte_hold: got %h want A5", bus.byte_data); else pass_cnt++;
        drive_phase(~HS, seg(4'h5), PHASE, s);
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, seg(4'h5), PHASE, s);
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, seg(4'h5), PHASE, s);
        exp_q.push_back(ev_t'{1'b1, 8'hA5, s + int'(SETTLE) + 5});
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL resume_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
            if (o !== e) $display("FAIL resume_event: got kind=%b data=%h cyc=%0d want kind=%b data=%h cyc=%0d",
                                  o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        total_cnt++; if (bus.data_valid !== 1'b1) $display("FAIL resume_valid: got %b want 1", bus.data_valid); else pass_cnt++;
    endtask

    task automatic test_byte_change();
        int s;
        ev_t e, o;
        drive_phase(HS,  seg(4'hA), PHASE, s);
        drive_phase(~HS, seg(4'hC), PHASE, s);
        drive_phase(HS,  seg(4'h3), PHASE, s);
        drive_phase(~HS, seg(4'hC), PHASE, s);
        drive_phase(HS,  seg(4'h3), PHASE, s);
        drive_phase(~HS, seg(4'hC), PHASE, s);
        exp_q.push_back(ev_t'{1'b1, 8'h3C, s + int'(SETTLE) + 5});
        drive_phase(HS,  seg(4'h3), PHASE, s);
        drive_phase(~HS, seg(4'hC), PHASE, s);
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL change_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
            if (o !== e) $display("FAIL change_event: got kind=%b data=%h cyc=%0d want kind=%b data=%h cyc=%0d",
                                  o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
        total_cnt++; if (bus.byte_data !== 8'h3C) $display("FAIL change_byte: got %h want 3C", bus.byte_data); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int s;
        ev_t e, o;
        drive_phase(HS, seg(4'h3), PHASE, s);
        bus.sevseg_sel = ~HS;
        bus.sevseg_led = ~seg(4'hC);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (bus.byte_data !== 8'h00) $display("FAIL midrst_byte: got %h want 00", bus.byte_data); else pass_cnt++;
        total_cnt++; if (bus.data_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", bus.data_valid); else pass_cnt++;
        total_cnt++; if (bus.update !== 1'b0) $display("FAIL midrst_update: got %b want 0", bus.update); else pass_cnt++;
        total_cnt++; if (bus.pattern_err !== 1'b0) $display("FAIL midrst_perr: got %b want 0", bus.pattern_err); else pass_cnt++;
        rst = 1'b0;
        repeat (PHASE) @(negedge clk);
        drive_phase(HS,  seg(4'h3), PHASE, s);
        drive_phase(~HS, seg(4'hC), PHASE, s);
        drive_phase(HS,  seg(4'h3), PHASE, s);
        drive_phase(~HS, seg(4'hC), PHASE, s);
        exp_q.push_back(ev_t'{1'b1, 8'h3C, s + int'(SETTLE) + 5});
        total_cnt++;
        if (obs_q.size() != exp_q.size()) $display("FAIL midrst_events: got %0d want %0d", obs_q.size(), exp_q.size());
        else pass_cnt++;
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); total_cnt++;
            if (o !== e) $display("FAIL midrst_event: got kind=%b data=%h cyc=%0d want kind=%b data=%h cyc=%0d",
                                  o.kind, o.data, o.cyc, e.kind, e.data, e.cyc);
            else pass_cnt++;
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        bus.sevseg_sel = 1'b0;
        bus.sevseg_led = 7'h7F;
        @(negedge clk);
        test_reset();
        test_first_byte();
        test_pattern_err();
        test_glitch();
        test_timeout();
        test_byte_change();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/sevseg_byte_reader.md
# sevseg_byte_reader

Receive side of the two-digit multiplexed seven-segment link: samples the active-low segment bus and digit-select line, demultiplexes the two digits, decodes each segment pattern back to a hex nibble and reconstructs the displayed byte. Sits on the pin/loopback side of the byte display driver, for self-test of the display path and capture of display traffic. It publishes a byte only after it has been stable over several frames.

## Interface
- SETTLE, 16: cycles after a select edge before the segment bus is sampled (≥2).
- STABLE_FRAMES, 2: identical consecutive frames required before publishing (1–15).
- TIMEOUT, 65536: cycles without a select edge before `data_valid` drops.
- HIGH_WHEN_SEL, 0: `sevseg_sel` level during which `sevseg_led` carries the high nibble.
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- sevseg_led  in  7  segment bus, active-low; bit0=a … bit6=g; asynchronous to clk.
- sevseg_sel  in  1  digit select; asynchronous to clk.
- byte_data  out  8  last published byte.
- data_valid  out  1  level; a byte has been published and select is still toggling.
- update  out  1  one-cycle pulse when `byte_data` is loaded.
- pattern_err  out  1  one-cycle pulse on an undecodable sample.

## Operation
- Synchronize `sevseg_led` and `sevseg_sel` through two flops each. Then invert the led bus to active-high pattern P, gfedcba.
- Decode table, P→nibble: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F.
- Any other P is an error, including blank 00.
- FSM states:
  - WAIT_EDGE: on a synchronized select edge, load settle counter=0 and go to SETTLING.
  - SETTLING: counter increments each cycle. At SETTLE-1, go to SAMPLE. A new select edge restarts the counter at 0 and stays in SETTLING; the aborted phase is never sampled.
  - SAMPLE, one cycle: decode P. The digit is high if synchronized sel == HIGH_WHEN_SEL, else low.
    - Valid P: write the nibble to its slot and set that slot's flag.
    - Invalid P: pulse `pattern_err`, clear both slot flags, reset the match count to 0.
    - Go to COMMIT on a valid low-digit sample; otherwise go to WAIT_EDGE.
  - COMMIT, one cycle:
    - If the high flag is clear, clear the low flag and go to WAIT_EDGE.
    - Otherwise candidate C={hi,lo}. If C==previous candidate, match count +1 (saturating at 15); else match count=1 and previous=C.
    - Clear both flags.
    - If match count ≥ STABLE_FRAMES and (C≠byte_data or data_valid==0): load byte_data=C, set data_valid, pulse update.
    - Go to WAIT_EDGE.
- A frame is one high sample followed by one low sample. A low sample with no preceding high sample is discarded, so a mixed old/new byte is never published.
- Timeout counter:
  - Clears on every synchronized select edge and otherwise saturates.
  - On reaching TIMEOUT-1: clear data_valid, match count, previous candidate and slot flags. `byte_data` holds its value.

## Timing
- Reset values:
  - Outputs: byte_data=00, data_valid=0, update=0, pattern_err=0.
  - FSM=WAIT_EDGE; all counters, flags and previous candidate=0.
  - Sync flops: led=7F (blank), sel=0.
- Reset mid-operation: all of the above take effect on the next clk edge. No partial frame survives.
- Latency from raw sel edge:
  - 2 cycles sync + 1 cycle edge detect → E.
  - SAMPLE at E+SETTLE; COMMIT at E+SETTLE+1.
  - byte_data/update registered at E+SETTLE+2.
- update and pattern_err are never high in the same cycle. update is never high without data_valid high in the same cycle.
- Minimum select phase that is sampled: SETTLE+2 cycles. Shorter phases are silently dropped.
- A select edge during SAMPLE or COMMIT is captured and starts the next SETTLING on the following cycle.

## Test plan
- Drive 0xA5 (high digit 77, low 6D, inverted on the bus) with 200-cycle phases and defaults → exactly one update; byte_data=A5, data_valid=1, no pattern_err.
- Switch the driven byte to 3C mid-frame → next update after 2 matching full frames, byte_data=3C; no intermediate value such as A3C-mixed A C published; one update per change.
- Drive low-digit P=12 (undecodable) for one phase → one pattern_err pulse; byte_data stays A5; the next 2 good frames produce no update (unchanged byte).
- Toggle select twice within 5 cycles, then hold → no SAMPLE in the glitch phase; sample occurs SETTLE cycles after the last edge.
- Stop toggling select → data_valid falls exactly TIMEOUT cycles after the last synchronized edge; byte_data holds A5.
  - Resume toggling → update re-asserts after STABLE_FRAMES frames, even with an unchanged byte.
- Assert rst in SETTLING with one slot filled → next cycle all outputs at reset values; first update only after 2 complete new frames.
